// File: rtl/aes_pkg.sv
// Shared AES definitions: word/block types, the S-box and the key-schedule round constants.
// Used by the key expander and by the encrypt/decrypt pipes.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;
  typedef block_t       round_keys_t [14:0];

  // Entry 0 is padding so the table can be indexed directly by the 3-bit iteration count.
  localparam logic [7:0] RCON [0:7] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  localparam logic [0:255][7:0] SBOX_TABLE = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: the AES S-box applied to each byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t word_in,
  output word_t word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/expand_key.sv
// AES-256 key expansion: captures a 256-bit key and produces two round keys (eight words)
// per cycle, presenting all 15 round keys in parallel with a level valid once complete.
module expand_key
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ready,
  input  logic [255:0] key_in,
  output round_keys_t  key_out,
  output logic         valid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0] state;
  logic [2:0] k;
  logic [2:0] pair_sel;
  logic [3:0] rd_lo, rd_hi, wr_lo, wr_hi;
  block_t     prev_lo, prev_hi;
  word_t      rot_word, sub_rot, sub_mid;
  word_t      n0, n1, n2, n3, n4, n5, n6, n7;

  // Outside EXPAND k is 0; clamp so every read index stays inside the 15-entry array.
  assign pair_sel = (k == 3'd0) ? 3'd1 : k;
  assign rd_lo    = {pair_sel - 3'd1, 1'b0};
  assign rd_hi    = {pair_sel - 3'd1, 1'b1};
  assign wr_lo    = {pair_sel, 1'b0};
  assign wr_hi    = {pair_sel, 1'b1};

  assign prev_lo  = key_out[rd_lo];
  assign prev_hi  = key_out[rd_hi];
  assign rot_word = {prev_hi[23:0], prev_hi[31:24]};

  aes_sub_word u_sub_rot (
    .word_in  (rot_word),
    .word_out (sub_rot)
  );

  assign n0 = prev_lo[127:96] ^ sub_rot ^ {RCON[k], 24'h0};
  assign n1 = prev_lo[95:64]  ^ n0;
  assign n2 = prev_lo[63:32]  ^ n1;
  assign n3 = prev_lo[31:0]   ^ n2;

  aes_sub_word u_sub_mid (
    .word_in  (n3),
    .word_out (sub_mid)
  );

  assign n4 = prev_hi[127:96] ^ sub_mid;
  assign n5 = prev_hi[95:64]  ^ n4;
  assign n6 = prev_hi[63:32]  ^ n5;
  assign n7 = prev_hi[31:0]   ^ n6;

  // The last iteration only fills entry 14; its upper four words are not part of the schedule.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= 3'd0;
      valid <= 1'b0;
      for (int i = 0; i < 15; i++) begin
        key_out[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ready) begin
            key_out[0] <= key_in[255:128];
            key_out[1] <= key_in[127:0];
            k          <= 3'd1;
            valid      <= 1'b0;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          key_out[wr_lo] <= {n0, n1, n2, n3};
          if (k == 3'd7) begin
            state <= DONE;
            valid <= 1'b1;
            k     <= 3'd0;
          end else begin
            key_out[wr_hi] <= {n4, n5, n6, n7};
            k              <= k + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expand_key.sv
// Directed bench for expand_key: FIPS-197 vectors from a table plus multi-cycle sequences
// (latency, ignored re-strobe, restart from DONE, reset mid-expansion) against a word-wise model.
module tb_expand_key;
  import aes_pkg::*;

  localparam logic [255:0] KEY_C3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_ZERO = 256'h0;
  localparam logic [255:0] KEY_ONE  = 256'd1;
  localparam logic [255:0] KEY_A    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_B    = 256'hdeadbeef0123456789abcdeffedcba9876543210cafef00d5a5aa5a5c3c33c3c;
  localparam int NVEC = 11;

  typedef struct {
    logic [255:0] key;
    int           idx;
    block_t       expected;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ready;
  logic [255:0] key_in;
  block_t       key_out [14:0];
  logic         valid;

  int     vectors = 0;
  int     miscompares = 0;
  int     cycles;
  block_t exp_keys [15];
  block_t old14;
  vec_t   vecs [NVEC];

  expand_key dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ready   (ready),
    .key_in  (key_in),
    .key_out (key_out),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One-cycle ready strobe; returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [255:0] key);
    ready  = 1'b1;
    key_in = key;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Straight word-at-a-time FIPS-197 expansion for Nk = 8.
  task automatic compute_model(input logic [255:0] key);
    word_t      w [60];
    word_t      t;
    logic [7:0] rc;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc << 1;
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_all(input string name);
    for (int r = 0; r < 15; r++)
      checkOutput($sformatf("%s key_out[%0d]", name, r), key_out[r], exp_keys[r]);
  endtask

  task automatic check_cleared(input string name);
    checkOutput({name, " valid"}, valid, 1'b0);
    for (int r = 0; r < 15; r++)
      checkOutput($sformatf("%s key_out[%0d]", name, r), key_out[r], 128'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{KEY_C3,   0,  128'h000102030405060708090a0b0c0d0e0f};
    vecs[1]  = '{KEY_C3,   1,  128'h101112131415161718191a1b1c1d1e1f};
    vecs[2]  = '{KEY_C3,   2,  128'ha573c29fa176c498a97fce93a572c09c};
    vecs[3]  = '{KEY_C3,   3,  128'h1651a8cd0244beda1a5da4c10640bade};
    vecs[4]  = '{KEY_C3,   14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vecs[5]  = '{KEY_ZERO, 0,  128'h0};
    vecs[6]  = '{KEY_ZERO, 2,  128'h62636363626363636263636362636363};
    vecs[7]  = '{KEY_ZERO, 3,  128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb};
    vecs[8]  = '{KEY_ZERO, 4,  128'h6f6c6ccf0d0f0fac6f6c6ccf0d0f0fac};
    vecs[9]  = '{KEY_ONE,  0,  128'h0};
    vecs[10] = '{KEY_ONE,  1,  128'h1};

    // Reset held two cycles with ready asserted: ready must be ignored.
    rst_n  = 1'b0;
    ready  = 1'b1;
    key_in = KEY_C3;
    repeat (2) tick();
    check_cleared("reset");
    rst_n = 1'b1;
    ready = 1'b0;
    tick();
    checkOutput("idle valid", valid, 1'b0);
    checkOutput("idle key_out[0]", key_out[0], 128'h0);

    // FIPS C.3 latency: entries 0..1 right after acceptance, pair 1 one edge later, valid at N+7.
    compute_model(KEY_C3);
    applyStimulus(KEY_C3);
    checkOutput("c3 valid at accept", valid, 1'b0);
    checkOutput("c3 key_out[0] at N", key_out[0], 128'h000102030405060708090a0b0c0d0e0f);
    checkOutput("c3 key_out[1] at N", key_out[1], 128'h101112131415161718191a1b1c1d1e1f);
    tick();
    checkOutput("c3 key_out[2] at N+1", key_out[2], 128'ha573c29fa176c498a97fce93a572c09c);
    checkOutput("c3 valid at N+1", valid, 1'b0);
    wait_valid(cycles);
    checkOutput("c3 latency", cycles + 1, 7);
    check_all("c3");

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].key);
      wait_valid(cycles);
      checkOutput($sformatf("vec%0d valid", i), valid, 1'b1);
      checkOutput($sformatf("vec%0d key_out[%0d]", i, vecs[i].idx), key_out[vecs[i].idx], vecs[i].expected);
    end

    // Key = 1, full schedule against the model.
    compute_model(KEY_ONE);
    applyStimulus(KEY_ONE);
    wait_valid(cycles);
    checkOutput("one latency", cycles, 7);
    check_all("one");

    // A second strobe on expansion cycle 3 must be ignored.
    compute_model(KEY_A);
    applyStimulus(KEY_A);
    repeat (2) tick();
    applyStimulus(KEY_B);
    wait_valid(cycles);
    checkOutput("repulse latency", cycles, 4);
    check_all("repulse");

    // Restart from DONE; key_in changes right after acceptance and must not matter.
    old14 = exp_keys[14];
    compute_model(KEY_B);
    applyStimulus(KEY_B);
    key_in = KEY_A;
    checkOutput("restart valid drop", valid, 1'b0);
    checkOutput("restart key_out[0]", key_out[0], exp_keys[0]);
    checkOutput("restart key_out[14] held", key_out[14], old14);
    wait_valid(cycles);
    checkOutput("restart latency", cycles, 7);
    check_all("restart");

    // Reset on the fourth expansion edge aborts and clears; a fresh strobe then completes.
    compute_model(KEY_C3);
    applyStimulus(KEY_C3);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check_cleared("midreset");
    rst_n = 1'b1;
    tick();
    checkOutput("midreset idle valid", valid, 1'b0);
    checkOutput("midreset idle key_out[2]", key_out[2], 128'h0);
    applyStimulus(KEY_C3);
    wait_valid(cycles);
    checkOutput("after reset latency", cycles, 7);
    check_all("after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
